hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Parametrised hazard/flush controller for the in-order RISC-V pipeline (IF/ID/EX/M/WB).
- Generates the pipeline-register enables and flushes:
  - multi-cycle load-use stall of configurable depth;
  - branch-mispredict recovery;
  - multi-cycle MDU (mul/div) occupancy of EX;
  - full-pipeline freeze on data-memory wait.
- Also provides saturating stall and mispredict performance counters.

Parameters:
REG_AW, 5, register address width
LOAD_STALL, 1, bubbles inserted per load-use hazard (legal 1..7)
MDU_EN, 1, 1 = honour mdu_start_e/mdu_done; 0 = ignore them (MDU_BUSY unreachable)
FLUSH_EX_M, 1, 1 = also flush EX/M on mispredict
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
load_e  in  1  instruction in EX is a load
rd_addr_e  in  REG_AW  destination register of EX instruction
rs1_addr_d  in  REG_AW  rs1 of ID instruction
rs2_addr_d  in  REG_AW  rs2 of ID instruction
rs1_used_d  in  1  ID instruction reads rs1
rs2_used_d  in  1  ID instruction reads rs2
br_valid_e  in  1  EX holds a resolved branch/jump
predict_e  in  1  predicted-taken bit carried with that branch
taken_e  in  1  actual outcome
mdu_start_e  in  1  MDU op entering execution in EX this cycle
mdu_done  in  1  MDU result ready
mem_wait  in  1  data memory not ready
pc_en  out  1  PC update enable
btb_en  out  1  BTB update enable
if_id_en  out  1  IF/ID load enable
id_ex_en  out  1  ID/EX load enable
ex_m_en  out  1  EX/M load enable
if_id_flush  out  1  clear IF/ID to NOP
id_ex_flush  out  1  clear ID/EX to NOP
ex_m_flush  out  1  clear EX/M to NOP
mispredict_o  out  1  mispredict recovery this cycle
busy_o  out  1  FSM not in RUN
stall_cnt  out  CNT_W  cycles with pc_en=0 since reset
flush_cnt  out  CNT_W  mispredicts since reset

Behaviour:

Reset and output timing:
- Reset: rst_n synchronous, active-low.
- While rst_n=0:
  - all *_en = 0 and all *_flush = 1;
  - mispredict_o = 0, busy_o = 0;
  - state ← RUN; stall counter register ← 0;
  - stall_cnt = flush_cnt = 0.
- Reset mid-stall abandons the stall immediately.
- Control outputs are combinational from registered state plus current inputs (zero latency). Counters are registered.
- Default output set: all *_en = 1, all *_flush = 0, mispredict_o = 0.

Hazard terms:
- lu = load_e & (rd_addr_e != 0) & ((rs1_used_d & rd_addr_e == rs1_addr_d) | (rs2_used_d & rd_addr_e == rs2_addr_d)).
- mp = br_valid_e & (predict_e ^ taken_e).

FSM states RUN, LD_STALL, MDU_BUSY. Priority in every state: mem_wait > state-specific actions.
- mem_wait=1 in any state:
  - all *_en = 0, no flush;
  - state and stall counter hold;
  - mp, lu and mdu_start_e are not acted on.
- RUN, first matching condition wins:
  1. mp:
     - pc_en = 1;
     - if_id_en = 0, btb_en = 0;
     - if_id_flush = 1, id_ex_flush = 1;
     - ex_m_flush = FLUSH_EX_M;
     - mispredict_o = 1; stay in RUN.
     - mp overrides lu: the dependent instruction is wrong-path.
  2. mdu_start_e & MDU_EN:
     - pc_en = btb_en = if_id_en = id_ex_en = 0;
     - ex_m_flush = 1;
     - go to MDU_BUSY.
     - mdu_done is ignored in RUN.
  3. lu:
     - pc_en = btb_en = if_id_en = 0;
     - id_ex_flush = 1;
     - if LOAD_STALL > 1: load stall counter with LOAD_STALL−1 and go to LD_STALL; otherwise stay in RUN.
- LD_STALL:
  - outputs same as the lu case;
  - decrement counter; when counter = 1 in this cycle, go to RUN.
  - Total bubbles per hazard = LOAD_STALL.
  - br_valid_e, lu and mdu_start_e are ignored (EX holds a bubble).
- MDU_BUSY:
  - mdu_done=0: outputs same as the MDU-start case.
  - mdu_done=1: default outputs (EX result advances) and go to RUN.
  - Other hazard inputs are ignored.
- busy_o = (state != RUN).

Counters:
- stall_cnt increments each non-reset cycle with pc_en=0.
- flush_cnt increments each cycle with mispredict_o=1.
- Both saturate at all-ones (no wrap).
- rd_addr_e = 0 never triggers lu.

Test Plan:
- Load-use, LOAD_STALL=1: load_e=1, rd_addr_e=5, rs1_addr_d=5, rs1_used_d=1 for 1 cycle → pc_en=if_id_en=0 and id_ex_flush=1 for exactly 1 cycle; busy_o stays 0; stall_cnt=1.
- Load-use, LOAD_STALL=3: same stimulus, inputs cleared after cycle 0 → stall outputs held 3 cycles; busy_o=1 in cycles 1–2; stall_cnt=3.
- mem_wait=1 for 2 cycles asserted in the 2nd LD_STALL cycle → all enables 0 for 2 cycles; bubble count still 3; stall_cnt=5.
- Mispredict with simultaneous lu: br_valid_e=1, predict_e=0, taken_e=1, plus a load-use match → pc_en=1; if_id_flush=id_ex_flush=ex_m_flush=1; mispredict_o=1; flush_cnt=1; no LD_STALL entry.
- MDU: mdu_start_e pulse, mdu_done high 4 cycles later → pc_en=id_ex_en=0 and ex_m_flush=1 for 4 cycles; in the mdu_done cycle all enables=1; state RUN.
- Reset during MDU_BUSY; also rd_addr_e=0 with load and matching rs1=0 → all flushes=1 and enables=0 during reset, then RUN; zero-register case produces no stall.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard/flush controller with load-use, mispredict, MDU and mem-wait handling
// Control outputs are combinational from registered state; performance counters are registered.
module hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int MDU_EN     = 1,
  parameter int FLUSH_EX_M = 1,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_e,
  input  logic [REG_AW-1:0] rd_addr_e,
  input  logic [REG_AW-1:0] rs1_addr_d,
  input  logic [REG_AW-1:0] rs2_addr_d,
  input  logic              rs1_used_d,
  input  logic              rs2_used_d,
  input  logic              br_valid_e,
  input  logic              predict_e,
  input  logic              taken_e,
  input  logic              mdu_start_e,
  input  logic              mdu_done,
  input  logic              mem_wait,
  output logic              pc_en,
  output logic              btb_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_m_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_m_flush,
  output logic              mispredict_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {RUN, LD_STALL, MDU_BUSY} state_t;

  localparam logic [2:0] LS_RELOAD = 3'(LOAD_STALL - 1);

  state_t             state_q, state_d;
  logic [2:0]         bub_q, bub_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               lu, mp;

  assign lu = load_e && (rd_addr_e != '0) &&
              ((rs1_used_d && (rd_addr_e == rs1_addr_d)) ||
               (rs2_used_d && (rd_addr_e == rs2_addr_d)));
  assign mp = br_valid_e && (predict_e ^ taken_e);

  always_comb begin
    pc_en        = 1'b1;
    btb_en       = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_m_en      = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_m_flush   = 1'b0;
    mispredict_o = 1'b0;
    state_d      = state_q;
    bub_d        = bub_q;

    if (!rst_n) begin
      pc_en       = 1'b0;
      btb_en      = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_m_en     = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      ex_m_flush  = 1'b1;
      state_d     = RUN;
      bub_d       = 3'd0;
    end else if (mem_wait) begin
      // Whole pipeline freezes; no hazard is acted on until memory answers.
      pc_en    = 1'b0;
      btb_en   = 1'b0;
      if_id_en = 1'b0;
      id_ex_en = 1'b0;
      ex_m_en  = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (mp) begin
            // Wrong-path instructions are squashed, so a dependent lu is moot.
            if_id_en     = 1'b0;
            btb_en       = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_m_flush   = (FLUSH_EX_M != 0);
            mispredict_o = 1'b1;
          end else if (mdu_start_e && (MDU_EN != 0)) begin
            pc_en      = 1'b0;
            btb_en     = 1'b0;
            if_id_en   = 1'b0;
            id_ex_en   = 1'b0;
            ex_m_flush = 1'b1;
            state_d    = MDU_BUSY;
          end else if (lu) begin
            pc_en       = 1'b0;
            btb_en      = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            if (LOAD_STALL > 1) begin
              bub_d   = LS_RELOAD;
              state_d = LD_STALL;
            end
          end
        end
        LD_STALL: begin
          pc_en       = 1'b0;
          btb_en      = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          bub_d       = bub_q - 3'd1;
          if (bub_q == 3'd1) state_d = RUN;
        end
        MDU_BUSY: begin
          if (mdu_done) begin
            state_d = RUN;
          end else begin
            pc_en      = 1'b0;
            btb_en     = 1'b0;
            if_id_en   = 1'b0;
            id_ex_en   = 1'b0;
            ex_m_flush = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!rst_n) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!pc_en && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (mispredict_o && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    bub_q       <= bub_d;
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  // State may still be stale in the first reset cycle, so gate busy with reset.
  assign busy_o    = rst_n && (state_q != RUN);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
